// File: rtl/text_buffer_if.sv
// rtl/text_buffer_if.sv - byte-write handshake and pixel-scan port bundle for text_buffer
interface text_buffer_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [9:0] x;
    logic [9:0] y;
    logic [6:0] ascii_char;
    logic       cursor_on;

    modport master (output wr_en, wr_data, x, y, input wr_ready, ascii_char, cursor_on);
    modport slave  (input wr_en, wr_data, x, y, output wr_ready, ascii_char, cursor_on);
endinterface

// File: rtl/text_buffer.sv
// rtl/text_buffer.sv - 80x30 character-cell text memory with hardware cursor and scan read port
// Optional cursor blink: define TEXT_BUFFER_CURSOR_BLINK_EN.
module text_buffer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_CYCLES = 50_000_000
) (
    input  logic         clk,
    input  logic         reset_n,
    text_buffer_if.slave bus
);
    localparam int         CELLS = ROWS * COLS;
    localparam int         AW    = $clog2(CELLS);
    localparam int         RW    = $clog2(ROWS);
    localparam int         CW    = $clog2(COLS);
    localparam logic [6:0] SPACE = 7'h20;

    typedef enum logic [1:0] {CLEAR, IDLE, LINE_CLEAR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          wr_ready_q, wr_ready_d;
    logic [6:0]    ascii_q, ascii_d;
    logic          cursor_q, cursor_d;

    logic [6:0]    mem_q [CELLS];
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [6:0]    mem_wd;

    logic          accept;
    logic [6:0]    byte_in;
    logic [AW-1:0] row_base;
    logic [AW-1:0] cur_addr;
    logic [RW-1:0] row_next;
    logic          blink_vis;

    logic [5:0]    scan_row;
    logic [6:0]    scan_col;
    logic          scan_in;
    logic [AW-1:0] scan_addr;
    logic          unused_bits;

    assign accept   = bus.wr_en && wr_ready_q;
    assign byte_in  = bus.wr_data[6:0];
    assign row_base = AW'(row_q) * AW'(COLS);
    assign cur_addr = row_base + AW'(col_q);
    assign row_next = (32'(row_q) == ROWS - 1) ? '0 : row_q + 1'b1;

    assign scan_row  = bus.y[9:4];
    assign scan_col  = bus.x[9:3];
    assign scan_in   = (32'(scan_row) < ROWS) && (32'(scan_col) < COLS);
    assign scan_addr = scan_in ? AW'(scan_row) * AW'(COLS) + AW'(scan_col) : '0;

    assign unused_bits = ^{bus.x[2:0], bus.y[3:0], bus.wr_data[7], BLINK_CYCLES > 0};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        wr_ready_d = wr_ready_q;
        mem_we     = 1'b0;
        mem_wa     = cnt_q;
        mem_wd     = SPACE;
        case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                if (32'(cnt_q) == CELLS - 1) begin
                    cnt_d      = '0;
                    state_d    = IDLE;
                    wr_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LINE_CLEAR: begin
                // row_q already points at the row being entered
                mem_we = 1'b1;
                mem_wa = row_base + cnt_q;
                if (32'(cnt_q) == COLS - 1) begin
                    cnt_d      = '0;
                    state_d    = IDLE;
                    wr_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (accept) begin
                    if (byte_in >= 7'h20 && byte_in <= 7'h7E) begin
                        mem_we = 1'b1;
                        mem_wa = cur_addr;
                        mem_wd = byte_in;
                        if (32'(col_q) == COLS - 1) begin
                            col_d      = '0;
                            row_d      = row_next;
                            cnt_d      = '0;
                            state_d    = LINE_CLEAR;
                            wr_ready_d = 1'b0;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        case (byte_in)
                            7'h0D: col_d = '0;
                            7'h0A: begin
                                row_d      = row_next;
                                cnt_d      = '0;
                                state_d    = LINE_CLEAR;
                                wr_ready_d = 1'b0;
                            end
                            7'h08: begin
                                if (col_q != '0) begin
                                    col_d  = col_q - 1'b1;
                                    mem_we = 1'b1;
                                    mem_wa = cur_addr - 1'b1;
                                    mem_wd = SPACE;
                                end
                            end
                            7'h0C: begin
                                row_d      = '0;
                                col_d      = '0;
                                cnt_d      = '0;
                                state_d    = CLEAR;
                                wr_ready_d = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Registered read samples the pre-write contents, giving read-first behaviour
    always_comb begin
        ascii_d  = scan_in ? mem_q[scan_addr] : SPACE;
        cursor_d = scan_in && (32'(scan_row) == 32'(row_q)) &&
                   (32'(scan_col) == 32'(col_q)) && blink_vis;
    end

`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blink_vis_q, blink_vis_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 32'd1;
        blink_vis_d = blink_vis_q;
        if (accept) begin
            blink_cnt_d = '0;
            blink_vis_d = 1'b1;
        end else if (blink_cnt_q == 32'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            blink_vis_d = ~blink_vis_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            blink_vis_q <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_vis_q <= blink_vis_d;
        end
    end

    assign blink_vis = blink_vis_q;
`else
    assign blink_vis = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            wr_ready_q <= 1'b0;
            ascii_q    <= '0;
            cursor_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wr_ready_q <= wr_ready_d;
            ascii_q    <= ascii_d;
            cursor_q   <= cursor_d;
        end
    end

    assign bus.wr_ready   = wr_ready_q;
    assign bus.ascii_char = ascii_q;
    assign bus.cursor_on  = cursor_q;
endmodule

// File: tb/tb_text_buffer.sv
// tb/tb_text_buffer.sv - scoreboard testbench for text_buffer (default build, cursor always visible)
`timescale 1ns/1ps
module tb_text_buffer;
    logic clk = 1'b0;
    logic reset_n;

    text_buffer_if bus();

    text_buffer #(
        .COLS        (80),
        .ROWS        (30),
        .BLINK_CYCLES(50_000_000)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         col;
        int         row;
        logic [6:0] ch;
        logic       cur;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic rd_v     = 1'b0;
    logic rd_pend  = 1'b0;

    // Scan requests issued mid-cycle are captured at the next edge; compare at the following negedge
    always @(posedge clk) rd_pend <= rd_v;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rd_pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scan_unexpected actual ascii=%h cursor=%b required no output",
                         bus.ascii_char, bus.cursor_on);
            end else begin
                e = exp_q.pop_front();
                if (bus.ascii_char !== e.ch || bus.cursor_on !== e.cur) begin
                    failures++;
                    $display("FAIL scan(c%0d,r%0d) actual ascii=%h cursor=%b required ascii=%h cursor=%b",
                             e.col, e.row, bus.ascii_char, bus.cursor_on, e.ch, e.cur);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rd_v = 1'b0;
    endtask

    task automatic scan(input int col, input int row, input logic [6:0] ch, input logic cur);
        exp_t e;
        @(posedge clk);
        #1;
        bus.x = 10'(col * 8 + 3);
        bus.y = 10'(row * 16 + 7);
        e.col = col; e.row = row; e.ch = ch; e.cur = cur;
        exp_q.push_back(e);
        rd_v = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.wr_ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        if (bus.wr_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=%b required=1", bus.wr_ready);
        end
    endtask

    task automatic send(input logic [7:0] b);
        tick();
        wait_ready();
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (n < 3000) begin
            tick();
            n++;
            if (bus.wr_ready === 1'b1) break;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        exp_t e;
        reset_n     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.x       = 10'd0;
        bus.y       = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wr_ready", 32'(bus.wr_ready), 0);
        check("reset_ascii", 32'(bus.ascii_char), 0);
        check("reset_cursor", 32'(bus.cursor_on), 0);

        // Abort a CLEAR sweep partway, then the full clear must restart
        reset_n = 1'b1;
        repeat (100) tick();
        reset_n = 1'b0;
        #1;
        check("midclear_reset_ready", 32'(bus.wr_ready), 0);
        tick(); tick();
        reset_n = 1'b1;
        measure_low(n);
        check("clear_low_cycles", n, 2400);

        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                scan(c, r, 7'h20, (r == 0 && c == 0));
        scan(80, 0, 7'h20, 1'b0);
        scan(0, 30, 7'h20, 1'b0);
        scan(127, 63, 7'h20, 1'b0);

        send(8'h41);
        check("ready_after_print", 32'(bus.wr_ready), 1);
        scan(0, 0, 7'h41, 1'b0);
        scan(1, 0, 7'h20, 1'b1);

        send(8'h0D);
        for (int i = 0; i < 80; i++) send(8'h42);
        measure_low(n);
        check("row_wrap_low_cycles", n, 80);
        for (int c = 0; c < 80; c++) scan(c, 0, 7'h42, 1'b0);
        for (int c = 0; c < 80; c++) scan(c, 1, 7'h20, (c == 0));

        for (int i = 0; i < 29; i++) begin
            send(8'h0A);
            measure_low(n);
            check("lf_low_cycles", n, 80);
        end
        for (int c = 0; c < 80; c++) scan(c, 0, 7'h20, (c == 0));
        scan(0, 29, 7'h20, 1'b0);

        send(8'h41);
        send(8'h42);
        send(8'h08);
        check("ready_after_bs", 32'(bus.wr_ready), 1);
        scan(0, 0, 7'h41, 1'b0);
        scan(1, 0, 7'h20, 1'b1);
        scan(2, 0, 7'h20, 1'b0);
        send(8'h0D);
        scan(0, 0, 7'h41, 1'b1);
        send(8'h08);
        scan(0, 0, 7'h41, 1'b1);
        scan(1, 0, 7'h20, 1'b0);
        send(8'h07);
        check("ready_after_ignored", 32'(bus.wr_ready), 1);
        scan(0, 0, 7'h41, 1'b1);
        send(8'hC3);
        scan(0, 0, 7'h43, 1'b0);
        scan(1, 0, 7'h20, 1'b1);
        send(8'h0A);
        measure_low(n);
        check("lf_midrow_low_cycles", n, 80);
        scan(1, 1, 7'h20, 1'b1);
        scan(0, 0, 7'h43, 1'b0);

        // FF with a write strobed into the busy window
        send(8'h0C);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h43;
        repeat (5) tick();
        bus.wr_en   = 1'b0;
        measure_low(n);
        check("ff_low_cycles", n + 5, 2400);
        scan(0, 0, 7'h20, 1'b1);
        scan(1, 0, 7'h20, 1'b0);
        scan(1, 1, 7'h20, 1'b0);

        // Write and read the same cell in one clock: old data first, new data next clock
        tick();
        wait_ready();
        bus.x = 10'd3;
        bus.y = 10'd7;
        e.col = 0; e.row = 0; e.ch = 7'h20; e.cur = 1'b1;
        exp_q.push_back(e);
        rd_v        = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h44;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        e.ch = 7'h44; e.cur = 1'b0;
        exp_q.push_back(e);
        scan(1, 0, 7'h20, 1'b1);
        scan(0, 0, 7'h44, 1'b0);

        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/text_buffer.md
# text_buffer

Character-cell text memory for the VGA text path. It accepts a byte stream of ASCII characters and control codes, for example from a UART receiver, and stores printable characters at a hardware cursor on an 80×30 grid of 8×16 glyph cells. It sits between the pixel-scan timing generator and the ASCII glyph renderer. For each pixel coordinate `x`, `y` it returns the 7-bit code of the character occupying that cell, plus a cursor flag. The renderer forms its glyph-ROM address from these as `{ascii_char, y[3:0]}`.

## Interface
- `COLS`, 80, character columns; cell column = `x[9:3]`.
- `ROWS`, 30, character rows; cell row = `y[9:4]`.
- `BLINK_CYCLES`, 50_000_000, clocks per cursor blink half-period. Used only with blink compiled in.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  byte-valid strobe; the byte is accepted only when `wr_en && wr_ready`.
- `wr_data`  in  8  byte to process; bit 7 is ignored.
- `wr_ready`  out  1  high when a byte can be accepted.
- `x`  in  10  pixel column from the scan generator.
- `y`  in  10  pixel row from the scan generator.
- `ascii_char`  out  7  code of the character under (`x`, `y`).
- `cursor_on`  out  1  high when (`x`, `y`) lies inside the cursor cell and the cursor is visible.

## Operation
- **Storage:** `ROWS*COLS` × 7-bit RAM, linear address `row*COLS + col`. One write port (FSM) and one registered read port (scan).
- **FSM states:** CLEAR, IDLE, LINE_CLEAR.
- **Reset:**
  - State = CLEAR, clear address = 0, cursor = (row 0, col 0).
  - `wr_ready`, `ascii_char`, `cursor_on` all = 0.
- **CLEAR:**
  - Writes 0x20 to one address per clock, from 0 to `ROWS*COLS-1`, which is 2400 clocks.
  - Then goes to IDLE.
  - `wr_ready` = 0 throughout.
- **IDLE:** `wr_ready` = 1. An accepted byte `b = wr_data[6:0]` is handled in the same clock:
  - **0x20–0x7E:** write `b` at the cursor, then col+1.
    - If col was `COLS-1`: col = 0, row = (row+1) mod `ROWS`, and go to LINE_CLEAR.
  - **0x0D (CR):** col = 0.
  - **0x0A (LF):** row = (row+1) mod `ROWS`, col unchanged, go to LINE_CLEAR.
  - **0x08 (BS):**
    - If col > 0: col−1 and write 0x20 at the new position.
    - At col 0: no action.
  - **0x0C (FF):** cursor = (0,0), go to CLEAR.
  - **Any other code:** ignored. The byte is still accepted.
- **LINE_CLEAR:**
  - Writes 0x20 to cols 0..`COLS-1` of the new cursor row, one per clock (`COLS` clocks).
  - Then goes to IDLE.
  - `wr_ready` = 0 throughout.
- **Wrap-around:** moving past the last row goes to row 0, and that row is cleared. The buffer does not scroll.
- **Scan read:**
  - When row < `ROWS` and col < `COLS`: `ascii_char` = RAM[row*COLS+col].
  - Otherwise `ascii_char` = 0x20 and `cursor_on` = 0.
- **Cursor:** `cursor_on` = 1 when the scan cell equals the cursor cell, subject to blink gating (see Configuration).

## Timing
- Read latency is exactly 1 clock. `ascii_char` and `cursor_on` are registered and aligned with each other, reflecting the `x`/`y` from the previous edge.
- The read port is read-first: a write and a read to the same address in the same clock return the old value. The new value is visible from the next clock.
- Accept-to-ready: printable, CR, BS and ignored codes leave `wr_ready` = 1 on the next clock.
  - LF or end-of-row wrap: `wr_ready` = 0 for exactly `COLS` clocks.
  - FF: `wr_ready` = 0 for exactly `ROWS*COLS` clocks.
- A `wr_en` pulse while `wr_ready` = 0 is dropped. The buffer has no input queue.
- If `reset_n` asserts mid-CLEAR or mid-LINE_CLEAR, the sweep aborts immediately. The full CLEAR restarts at address 0 on deassertion.
- The scan read path runs in every state. Cells not yet cleared read their current RAM contents.

## Configuration
- **`TEXT_BUFFER_CURSOR_BLINK_EN` defined:**
  - A counter toggles a visibility bit every `BLINK_CYCLES` clocks; `cursor_on` is gated by that bit.
  - Counter and bit reset to 0/visible.
  - Any accepted byte restarts the counter and forces visible.
- **Not defined:** the cursor is always visible, and no counter is synthesised.

## Test plan
- **Reset clear:** release `reset_n` → `wr_ready` = 0 for 2400 clocks, then 1. Every cell read via `x`/`y` scan returns 0x20.
- **Printable write:** write 0x41 at (0,0). Then `x`=0, `y`=0 → `ascii_char` = 0x41 one clock later. Cursor moves to col 1: `x`=8, `y`=0 → `cursor_on` = 1.
- **End-of-row wrap:** write 80 × 0x42 → `wr_ready` drops for 80 clocks after the 80th byte. Cursor is at (1,0), row 1 all 0x20, row 0 all 0x42.
- **Last-row wrap:** LF × 30 from row 0 → cursor at row 0. Previously written row-0 text is replaced by 0x20.
- **BS and CR:** write "AB", BS → cell (0,1) = 0x20, cursor at col 1. Then CR → col 0. BS at col 0 → no change.
- **Dropped write and FF:** FF → `wr_ready` low 2400 clocks; 0x43 strobed during that window is not stored. Cursor reads back at (0,0).
